// File: rtl/mmcm_drp_seq.sv
// MMCM reconfiguration sequencer: holds the MMCM in reset, read-modify-writes a
// table of DRP registers, releases reset and waits for a stable lock.
module mmcm_drp_seq #(
  parameter int NREG         = 4,
  parameter int RESET_CYCLES = 100,
  parameter int LOCK_STABLE  = 16,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int DRP_TIMEOUT  = 255
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 start,
  input  logic [NREG*7-1:0]    cfg_addr,
  input  logic [NREG*16-1:0]   cfg_mask,
  input  logic [NREG*16-1:0]   cfg_data,
  output logic [6:0]           daddr,
  output logic                 den,
  output logic                 dwe,
  output logic [15:0]          di,
  input  logic [15:0]          drp_do,   // DRP DO; "do" is a reserved word
  input  logic                 drdy,
  output logic                 mmcm_rst,
  input  logic                 locked,
  output logic                 dsp_resetn,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [2:0] {
    HOLD         = 3'd0,
    RD           = 3'd1,
    RD_WAIT      = 3'd2,
    WR           = 3'd3,
    WR_WAIT      = 3'd4,
    RELEASE_WAIT = 3'd5,
    RUN          = 3'd6,
    ERR          = 3'd7
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [31:0]     stab_q, stab_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            pend_q, pend_d;
  logic [15:0]     wdata_q, wdata_d;
  logic            error_q, error_d;
  logic            mmcm_rst_q, mmcm_rst_d;
  logic            dsp_resetn_q, dsp_resetn_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            den_q, den_d;
  logic            dwe_q, dwe_d;
  logic [6:0]      daddr_q, daddr_d;
  logic [15:0]     di_q, di_d;

  function automatic logic [15:0] drp_merge(input logic [15:0] rd,
                                            input logic [15:0] mask,
                                            input logic [15:0] data);
    return (rd & mask) | (data & ~mask);
  endfunction

  function automatic logic [6:0] entry_addr(input logic [IW-1:0] i);
    return cfg_addr[7*int'(i) +: 7];
  endfunction

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stab_d  = stab_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    wdata_d = wdata_q;
    error_d = error_q;
    case (state_q)
      HOLD: begin
        stab_d = 32'd0;
        if (cnt_q == 32'(RESET_CYCLES - 1)) begin
          cnt_d   = 32'd0;
          state_d = pend_q ? RD : RELEASE_WAIT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RD: begin
        cnt_d   = 32'd0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (drdy) begin
          wdata_d = drp_merge(drp_do, cfg_mask[16*int'(idx_q) +: 16],
                              cfg_data[16*int'(idx_q) +: 16]);
          cnt_d   = 32'd0;
          state_d = WR;
        end else if (cnt_q == 32'(DRP_TIMEOUT - 1)) begin
          cnt_d   = 32'd0;
          error_d = 1'b1;
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      WR: begin
        cnt_d   = 32'd0;
        state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (drdy) begin
          cnt_d = 32'd0;
          if (idx_q == IW'(NREG - 1)) begin
            idx_d   = '0;
            pend_d  = 1'b0;
            state_d = RELEASE_WAIT;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = RD;
          end
        end else if (cnt_q == 32'(DRP_TIMEOUT - 1)) begin
          cnt_d   = 32'd0;
          error_d = 1'b1;
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RELEASE_WAIT: begin
        if (locked && (stab_q == 32'(LOCK_STABLE - 1))) begin
          cnt_d   = 32'd0;
          stab_d  = 32'd0;
          state_d = RUN;
        end else if (cnt_q == 32'(LOCK_TIMEOUT - 1)) begin
          cnt_d   = 32'd0;
          stab_d  = 32'd0;
          error_d = 1'b1;
          state_d = ERR;
        end else begin
          cnt_d  = cnt_q + 32'd1;
          stab_d = locked ? (stab_q + 32'd1) : 32'd0;
        end
      end
      RUN: begin
        // start outranks a simultaneous lock loss
        if (start) begin
          cnt_d   = 32'd0;
          idx_d   = '0;
          pend_d  = 1'b1;
          state_d = HOLD;
        end else if (!locked) begin
          cnt_d   = 32'd0;
          idx_d   = '0;
          pend_d  = 1'b0;
          state_d = HOLD;
        end else begin
          state_d = RUN;
        end
      end
      ERR: begin
        if (start) begin
          cnt_d   = 32'd0;
          idx_d   = '0;
          pend_d  = 1'b1;
          error_d = 1'b0;
          state_d = HOLD;
        end else begin
          state_d = ERR;
        end
      end
      default: begin
        cnt_d   = 32'd0;
        stab_d  = 32'd0;
        idx_d   = '0;
        pend_d  = 1'b0;
        state_d = HOLD;
      end
    endcase

    mmcm_rst_d   = !((state_d == RELEASE_WAIT) || (state_d == RUN));
    dsp_resetn_d = (state_d == RUN);
    busy_d       = !((state_d == RUN) || (state_d == ERR));
    done_d       = (state_q == RELEASE_WAIT) && (state_d == RUN);
    den_d        = (state_d == RD) || (state_d == WR);
    dwe_d        = (state_d == WR);
    daddr_d      = den_d ? entry_addr(idx_d) : 7'd0;
    di_d         = dwe_d ? wdata_d : 16'd0;
  end

  // State, counters and all outputs are registered together.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= HOLD;
      cnt_q        <= 32'd0;
      stab_q       <= 32'd0;
      idx_q        <= '0;
      pend_q       <= 1'b0;
      wdata_q      <= 16'd0;
      error_q      <= 1'b0;
      mmcm_rst_q   <= 1'b1;
      dsp_resetn_q <= 1'b0;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      den_q        <= 1'b0;
      dwe_q        <= 1'b0;
      daddr_q      <= 7'd0;
      di_q         <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      stab_q       <= stab_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      wdata_q      <= wdata_d;
      error_q      <= error_d;
      mmcm_rst_q   <= mmcm_rst_d;
      dsp_resetn_q <= dsp_resetn_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      den_q        <= den_d;
      dwe_q        <= dwe_d;
      daddr_q      <= daddr_d;
      di_q         <= di_d;
    end
  end

  assign mmcm_rst   = mmcm_rst_q;
  assign dsp_resetn = dsp_resetn_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign den        = den_q;
  assign dwe        = dwe_q;
  assign daddr      = daddr_q;
  assign di         = di_q;

endmodule

// File: tb/tb_mmcm_drp_seq.sv
// Directed bench for mmcm_drp_seq with a small DRP responder model and a
// hand-driven LOCKED input.
module tb_mmcm_drp_seq;

  localparam int NREG = 2;
  localparam int RC   = 100;
  localparam int LS   = 16;
  localparam int LT   = 2000;
  localparam int DT   = 255;

  logic                 clk = 1'b0;
  logic                 aresetn = 1'b0;
  logic                 start = 1'b0;
  logic                 locked = 1'b0;
  logic [NREG*7-1:0]    cfg_addr;
  logic [NREG*16-1:0]   cfg_mask;
  logic [NREG*16-1:0]   cfg_data;
  logic [6:0]           daddr;
  logic                 den, dwe;
  logic [15:0]          di;
  logic [15:0]          drp_do = 16'd0;
  logic                 drdy = 1'b0;
  logic                 mmcm_rst, dsp_resetn, busy, done, error;

  int checks = 0;
  int errors = 0;

  mmcm_drp_seq #(
    .NREG(NREG), .RESET_CYCLES(RC), .LOCK_STABLE(LS),
    .LOCK_TIMEOUT(LT), .DRP_TIMEOUT(DT)
  ) dut (
    .clk(clk), .aresetn(aresetn), .start(start),
    .cfg_addr(cfg_addr), .cfg_mask(cfg_mask), .cfg_data(cfg_data),
    .daddr(daddr), .den(den), .dwe(dwe), .di(di),
    .drp_do(drp_do), .drdy(drdy),
    .mmcm_rst(mmcm_rst), .locked(locked), .dsp_resetn(dsp_resetn),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // DRP register model: answers 3 cycles after den, logs every access.
  logic [23:0]  acc_log [0:63];
  int           n_acc = 0;
  int           n_rd = 0;
  int           hang_rd = 0;
  logic [15:0]  mem [0:127];
  logic [127:0] wrote = '0;
  logic         act = 1'b0;
  logic [2:0]   dly = 3'd0;
  logic [6:0]   a_l = 7'd0;
  logic         we_l = 1'b0;
  logic [15:0]  di_l = 16'd0;

  function automatic logic [15:0] init_val(input logic [6:0] a);
    case (a)
      7'h08:   return 16'hA3C7;
      7'h09:   return 16'h1234;
      default: return {9'h000, a};
    endcase
  endfunction

  always @(posedge clk) begin
    drdy <= 1'b0;
    if (den) begin
      act  <= 1'b1;
      dly  <= 3'd3;
      a_l  <= daddr;
      we_l <= dwe;
      di_l <= di;
      if (n_acc < 64) acc_log[n_acc] <= {dwe, daddr, di};
      n_acc <= n_acc + 1;
      if (!dwe) n_rd <= n_rd + 1;
    end else if (act) begin
      if (dly == 3'd1) begin
        act <= 1'b0;
        if (we_l || (n_rd != hang_rd)) begin
          drdy <= 1'b1;
          if (we_l) begin
            mem[a_l]   <= di_l;
            wrote[a_l] <= 1'b1;
          end else begin
            drp_do <= wrote[a_l] ? mem[a_l] : init_val(a_l);
          end
        end
      end else begin
        dly <= dly - 3'd1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cnt_rst_high(output int n);
    n = 0;
    while (mmcm_rst === 1'b1 && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_dsp(output int n, output int d);
    n = 0;
    d = 0;
    while (dsp_resetn !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
      d += int'(done);
    end
  endtask

  task automatic wait_err(output int n);
    n = 0;
    while (error !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n, d, base;
    cfg_addr = {7'h09, 7'h08};
    cfg_mask = {16'h00FF, 16'hF000};
    cfg_data = {16'h5A00, 16'h0145};

    // power-up bring-up
    repeat (3) @(negedge clk);
    chk("rst_mmcm_rst", mmcm_rst, 1);
    chk("rst_dsp_resetn", dsp_resetn, 0);
    chk("rst_den_dwe", {den, dwe}, 0);
    chk("rst_busy_done_err", {busy, done, error}, 3'b100);
    aresetn = 1'b1;
    cnt_rst_high(n);
    chk("pwr_rst_cycles", n, RC);
    repeat (50) @(negedge clk);
    locked = 1'b1;
    wait_dsp(n, d);
    chk("pwr_lock_to_dsp", n, LS);
    @(negedge clk);
    d += int'(done);
    chk("pwr_done_pulses", d, 1);
    chk("pwr_no_drp", n_acc, 0);
    chk("pwr_run_status", {busy, error, mmcm_rst}, 0);

    // reconfiguration; lock loss in the same cycle as start
    base = n_acc;
    start = 1'b1;
    locked = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("cfg_enter_hold", {busy, dsp_resetn, mmcm_rst}, 3'b101);
    cnt_rst_high(n);
    chk("cfg_acc_count", n_acc - base, 4);
    chk("cfg_rd0", acc_log[base + 0], {1'b0, 7'h08, 16'h0000});
    chk("cfg_wr0", acc_log[base + 1], {1'b1, 7'h08, 16'hA145});
    chk("cfg_rd1", acc_log[base + 2], {1'b0, 7'h09, 16'h0000});
    chk("cfg_wr1", acc_log[base + 3], {1'b1, 7'h09, 16'h5A34});
    repeat (10) @(negedge clk);
    locked = 1'b1;
    wait_dsp(n, d);
    chk("cfg_lock_to_dsp", n, LS);
    chk("cfg_done", d, 1);

    // second read never answered
    hang_rd = n_rd + 2;
    start = 1'b1;
    locked = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n_rd != hang_rd && n < 1000) begin
      @(negedge clk);
      n++;
    end
    wait_err(n);
    chk("drp_timeout_cycles", n, DT);
    chk("drp_err_outputs", {error, mmcm_rst, dsp_resetn, busy, den}, 5'b11000);
    hang_rd = 0;

    // rerun from ERR with new table contents
    cfg_mask = {16'hFF00, 16'hF000};
    cfg_data = {16'h00C3, 16'h0ABC};
    base = n_acc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rerun_err_clear", {error, busy}, 2'b01);
    cnt_rst_high(n);
    chk("rerun_acc_count", n_acc - base, 4);
    chk("rerun_wr0", acc_log[base + 1], {1'b1, 7'h08, 16'hAABC});
    chk("rerun_wr1", acc_log[base + 3], {1'b1, 7'h09, 16'h5AC3});
    repeat (10) @(negedge clk);
    locked = 1'b1;
    wait_dsp(n, d);
    chk("rerun_lock_to_dsp", n, LS);

    // one-cycle lock glitch in RUN
    base = n_acc;
    locked = 1'b0;
    @(negedge clk);
    chk("glitch_dsp_drop", {dsp_resetn, mmcm_rst}, 2'b01);
    cnt_rst_high(n);
    chk("glitch_rst_cycles", n, RC);
    repeat (20) @(negedge clk);
    locked = 1'b1;
    wait_dsp(n, d);
    chk("glitch_relock", n, LS);
    chk("glitch_no_drp", n_acc - base, 0);

    // lock never returns
    locked = 1'b0;
    @(negedge clk);
    cnt_rst_high(n);
    wait_err(n);
    chk("lock_timeout_cycles", n, LT);
    chk("lock_err_outputs", {mmcm_rst, dsp_resetn, busy}, 3'b100);

    // async reset during WR_WAIT, then ignored starts in HOLD
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(den && dwe) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #2 aresetn = 1'b0;
    #1;
    chk("arst_outputs", {mmcm_rst, dsp_resetn, den, dwe, busy, done, error}, 7'b1000100);
    chk("arst_drp_bus", {daddr, di}, 0);
    @(negedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    base = n_acc;
    n = 0;
    while (mmcm_rst === 1'b1 && n < 5000) begin
      start = (n == 5 || n == 40) ? 1'b1 : 1'b0;
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("hold_start_ignored_cycles", n, RC);
    repeat (5) @(negedge clk);
    locked = 1'b1;
    wait_dsp(n, d);
    chk("hold_start_relock", n, LS);
    chk("hold_start_no_drp", n_acc - base, 0);
    chk("hold_start_done", d, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
